dual_issue_scoreboard: RTL and testbench

Parametrised issue and hazard control for the dual-issue SPU core, sitting between the instruction decoder and the even/odd pipes. Keeps one countdown counter per architectural register: cycles until its pending result is written back. Issues the decoded even/odd instruction pair in order, splitting the pair when the odd slot conflicts. Resolves RAW and WAW hazards against in-flight results, and drops un-issued instructions on a taken branch.

---
 rtl/spu_issue_pkg.sv | 26 ++
 rtl/reg_countdown_bank.sv | 65 ++++++
 rtl/dual_issue_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_dual_issue_scoreboard.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_issue_pkg.sv
// Shared types and helpers for the SPU dual-issue scoreboard.
// Holds the issue FSM state enum, default sizing constants and the
// latency clamp used when a writer loads its destination counter.
package spu_issue_pkg;

  typedef enum logic [0:0] {
    PAIR     = 1'b0,  // both slots of the presented pair still pending
    ODD_ONLY = 1'b1   // even slot already issued, odd slot waiting
  } issue_state_e;

  localparam int DEF_NUM_REGS = 128;
  localparam int DEF_MAX_LAT  = 7;

  // A zero latency still occupies the register for one cycle; anything
  // longer than the slowest pipe saturates to that pipe's latency.
  function automatic int unsigned lat_clamp(input int unsigned lat,
                                            input int unsigned max_lat);
    if (lat == 0)
      return 1;
    else if (lat > max_lat)
      return max_lat;
    else
      return lat;
  endfunction

endpackage

// File: rtl/reg_countdown_bank.sv
// Purpose : one countdown counter per architectural register (cycles to writeback).
// Latency : reads combinational from registered counters; loads visible next cycle.
// Backpressure: none; two load ports accepted every cycle, odd load wins on equal address.
//
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   ld_even_*         even-pipe writer load (enable, register, latency)
//   ld_odd_*          odd-pipe writer load (enable, register, latency)
//   src_addr/src_cnt  six combinational source read ports
//   dst_addr/dst_cnt  two combinational destination read ports
//   busy              per-register counter non-zero
module reg_countdown_bank #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7,
  parameter int CNT_W    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_even_en,
  input  logic [ADDR_W-1:0]      ld_even_addr,
  input  logic [CNT_W-1:0]       ld_even_val,
  input  logic                   ld_odd_en,
  input  logic [ADDR_W-1:0]      ld_odd_addr,
  input  logic [CNT_W-1:0]       ld_odd_val,
  input  logic [5:0][ADDR_W-1:0] src_addr,
  output logic [5:0][CNT_W-1:0]  src_cnt,
  input  logic [1:0][ADDR_W-1:0] dst_addr,
  output logic [1:0][CNT_W-1:0]  dst_cnt,
  output logic [NUM_REGS-1:0]    busy
);

  logic [CNT_W-1:0] cnt [NUM_REGS];

  // A load overrides the decrement. Both pipes never legally target the
  // same register in one cycle; odd priority just keeps the result defined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_odd_en && (ld_odd_addr == ADDR_W'(i)))
          cnt[i] <= ld_odd_val;
        else if (ld_even_en && (ld_even_addr == ADDR_W'(i)))
          cnt[i] <= ld_even_val;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 6; k++)
      src_cnt[k] = cnt[src_addr[k]];
    for (int k = 0; k < 2; k++)
      dst_cnt[k] = cnt[dst_addr[k]];
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy[i] = (cnt[i] != '0);
  end

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Purpose : in-order dual-issue control with RAW/WAW hazard checks for the SPU even/odd pipes.
// Latency : issue decision combinational (zero cycles) from registered counters and state.
// Backpressure: pair held by decoder until pair_accept; odd slot may lag even by splitting the pair.
//
// Build option: define SB_FORWARD_EN to let sources issue when their counter is <= 1
// (bypass network present); otherwise a source must have a zero counter.
//
// Ports:
//   clk, reset                 core clock, asynchronous active-high reset
//   pair_valid / pair_accept   decoder handshake for the even/odd pair
//   valid_even, valid_odd      slot holds a real instruction
//   ra/rb/rc_even, use_even    even sources and their read enables
//   ra/rb/rt_st_odd, use_odd   odd sources and their read enables
//   rt_addr_*, reg_write_*     destination register and write enable per slot
//   lat_even, lat_odd          unit latency per slot (clamped to 1..MAX_LAT)
//   flush                      taken branch in odd pipe, discards the pair
//   issue_even, issue_odd      slot dispatched this cycle
//   busy                       per-register pending write
//   stall_cycles               saturating count of stalled pair cycles
module dual_issue_scoreboard
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int CNT_W    = $clog2(MAX_LAT + 1),
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pair_valid,
  output logic                pair_accept,
  input  logic                valid_even,
  input  logic                valid_odd,
  input  logic [ADDR_W-1:0]   ra_even,
  input  logic [ADDR_W-1:0]   rb_even,
  input  logic [ADDR_W-1:0]   rc_even,
  input  logic [ADDR_W-1:0]   ra_odd,
  input  logic [ADDR_W-1:0]   rb_odd,
  input  logic [ADDR_W-1:0]   rt_st_odd,
  input  logic [2:0]          use_even,
  input  logic [2:0]          use_odd,
  input  logic [ADDR_W-1:0]   rt_addr_even,
  input  logic [ADDR_W-1:0]   rt_addr_odd,
  input  logic                reg_write_even,
  input  logic                reg_write_odd,
  input  logic [CNT_W-1:0]    lat_even,
  input  logic [CNT_W-1:0]    lat_odd,
  input  logic                flush,
  output logic                issue_even,
  output logic                issue_odd,
  output logic [NUM_REGS-1:0] busy,
  output logic [PERF_W-1:0]   stall_cycles
);

  issue_state_e state, state_nxt;

  logic [5:0][CNT_W-1:0] src_cnt;
  logic [1:0][CNT_W-1:0] dst_cnt;
  logic [5:0]            src_rdy;
  logic [CNT_W-1:0]      lat_eff_even, lat_eff_odd;
  logic                  even_ok, odd_ok, pair_conflict;

  assign lat_eff_even = CNT_W'(lat_clamp(32'(lat_even), MAX_LAT));
  assign lat_eff_odd  = CNT_W'(lat_clamp(32'(lat_odd), MAX_LAT));

  reg_countdown_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .ld_even_en   (issue_even && reg_write_even),
    .ld_even_addr (rt_addr_even),
    .ld_even_val  (lat_eff_even),
    .ld_odd_en    (issue_odd && reg_write_odd),
    .ld_odd_addr  (rt_addr_odd),
    .ld_odd_val   (lat_eff_odd),
    .src_addr     ({rt_st_odd, rb_odd, ra_odd, rc_even, rb_even, ra_even}),
    .src_cnt      (src_cnt),
    .dst_addr     ({rt_addr_odd, rt_addr_even}),
    .dst_cnt      (dst_cnt),
    .busy         (busy)
  );

  // With a bypass the result can be picked up the cycle before writeback.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
`ifdef SB_FORWARD_EN
      src_rdy[k] = (src_cnt[k] <= CNT_W'(1));
`else
      src_rdy[k] = (src_cnt[k] == '0);
`endif
    end
  end

  // WAW: the new write must land strictly after the one in flight.
  assign even_ok = (&(src_rdy[2:0] | ~use_even)) &&
                   (!reg_write_even || (dst_cnt[0] < lat_eff_even));
  assign odd_ok  = (&(src_rdy[5:3] | ~use_odd)) &&
                   (!reg_write_odd || (dst_cnt[1] < lat_eff_odd));

  // Odd cannot see the even result when both go out together, and two
  // writers to one register in the same cycle would lose ordering.
  assign pair_conflict =
      (reg_write_even && ((use_odd[0] && (rt_addr_even == ra_odd)) ||
                          (use_odd[1] && (rt_addr_even == rb_odd)) ||
                          (use_odd[2] && (rt_addr_even == rt_st_odd)))) ||
      (reg_write_even && reg_write_odd && (rt_addr_even == rt_addr_odd));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= PAIR;
    else
      state <= state_nxt;
  end

  always_comb begin
    issue_even  = 1'b0;
    issue_odd   = 1'b0;
    pair_accept = 1'b0;
    state_nxt   = state;
    if (reset) begin
      state_nxt = PAIR;
    end else if (flush) begin
      pair_accept = pair_valid;
      state_nxt   = PAIR;
    end else if (pair_valid) begin
      case (state)
        PAIR: begin
          if (!valid_even) begin
            issue_odd   = valid_odd && odd_ok;
            pair_accept = (valid_odd && odd_ok) || !valid_odd;
          end else if (even_ok) begin
            issue_even = 1'b1;
            if (!valid_odd) begin
              pair_accept = 1'b1;
            end else if (odd_ok && !pair_conflict) begin
              issue_odd   = 1'b1;
              pair_accept = 1'b1;
            end else begin
              state_nxt = ODD_ONLY;
            end
          end
        end
        ODD_ONLY: begin
          if (odd_ok) begin
            issue_odd   = 1'b1;
            pair_accept = 1'b1;
            state_nxt   = PAIR;
          end
        end
        default: state_nxt = PAIR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (pair_valid && !pair_accept && !flush && (stall_cycles != '1))
      stall_cycles <= stall_cycles + PERF_W'(1);
  end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
module tb_dual_issue_scoreboard;

  localparam int NR     = 128;
  localparam int AW     = 7;
  localparam int MAXL   = 7;
  localparam int CW     = 4;
  localparam int PW     = 32;
`ifdef SB_FORWARD_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pair_valid, pair_accept, valid_even, valid_odd;
  logic [AW-1:0] ra_even, rb_even, rc_even, ra_odd, rb_odd, rt_st_odd;
  logic [2:0]    use_even, use_odd;
  logic [AW-1:0] rt_addr_even, rt_addr_odd;
  logic          reg_write_even, reg_write_odd;
  logic [CW-1:0] lat_even, lat_odd;
  logic          flush, issue_even, issue_odd;
  logic [NR-1:0] busy;
  logic [PW-1:0] stall_cycles;

  always #5 clk = ~clk;

  dual_issue_scoreboard #(
    .NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(MAXL), .CNT_W(CW), .PERF_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .pair_valid(pair_valid), .pair_accept(pair_accept),
    .valid_even(valid_even), .valid_odd(valid_odd),
    .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
    .ra_odd(ra_odd), .rb_odd(rb_odd), .rt_st_odd(rt_st_odd),
    .use_even(use_even), .use_odd(use_odd),
    .rt_addr_even(rt_addr_even), .rt_addr_odd(rt_addr_odd),
    .reg_write_even(reg_write_even), .reg_write_odd(reg_write_odd),
    .lat_even(lat_even), .lat_odd(lat_odd), .flush(flush),
    .issue_even(issue_even), .issue_odd(issue_odd),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: absolute cycle at which each register's pending write
  // has fully retired; remaining cycles = ready_at - now.
  int now;
  int ready_at [NR];
  bit split;
  int stall_m;
  bit exp_ie, exp_io, exp_acc, exp_split;

  function automatic int cnt_of(input int r);
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic int clampl(input int l);
    if (l == 0) return 1;
    if (l > MAXL) return MAXL;
    return l;
  endfunction

  function automatic bit srdy(input int a);
    return cnt_of(a) <= THR;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    split = 0;
    stall_m = 0;
  endfunction

  function automatic void predict();
    bit e_ok, o_ok, conf;
    e_ok = (!use_even[0] || srdy(int'(ra_even))) && (!use_even[1] || srdy(int'(rb_even))) &&
           (!use_even[2] || srdy(int'(rc_even))) &&
           (!reg_write_even || cnt_of(int'(rt_addr_even)) < clampl(int'(lat_even)));
    o_ok = (!use_odd[0] || srdy(int'(ra_odd))) && (!use_odd[1] || srdy(int'(rb_odd))) &&
           (!use_odd[2] || srdy(int'(rt_st_odd))) &&
           (!reg_write_odd || cnt_of(int'(rt_addr_odd)) < clampl(int'(lat_odd)));
    conf = (reg_write_even && ((use_odd[0] && rt_addr_even == ra_odd) ||
                               (use_odd[1] && rt_addr_even == rb_odd) ||
                               (use_odd[2] && rt_addr_even == rt_st_odd))) ||
           (reg_write_even && reg_write_odd && rt_addr_even == rt_addr_odd);
    exp_ie = 0; exp_io = 0; exp_acc = 0; exp_split = split;
    if (flush) begin
      exp_acc = pair_valid; exp_split = 0;
    end else if (pair_valid) begin
      if (split) begin
        exp_io = o_ok;
        if (o_ok) begin exp_acc = 1; exp_split = 0; end
      end else if (!valid_even) begin
        exp_io  = valid_odd && o_ok;
        exp_acc = exp_io || !valid_odd;
      end else if (e_ok) begin
        exp_ie = 1;
        if (!valid_odd) exp_acc = 1;
        else if (o_ok && !conf) begin exp_io = 1; exp_acc = 1; end
        else exp_split = 1;
      end
    end
  endfunction

  function automatic void commit();
    if (exp_ie && reg_write_even) ready_at[rt_addr_even] = now + 1 + clampl(int'(lat_even));
    if (exp_io && reg_write_odd)  ready_at[rt_addr_odd]  = now + 1 + clampl(int'(lat_odd));
    if (pair_valid && !exp_acc && !flush) stall_m++;
    split = exp_split;
    now++;
  endfunction

  task automatic settle();
    @(negedge clk);
    predict();
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic clear_inputs();
    pair_valid = 0; valid_even = 0; valid_odd = 0; flush = 0;
    ra_even = '0; rb_even = '0; rc_even = '0; ra_odd = '0; rb_odd = '0; rt_st_odd = '0;
    use_even = '0; use_odd = '0; rt_addr_even = '0; rt_addr_odd = '0;
    reg_write_even = 0; reg_write_odd = 0; lat_even = '0; lat_odd = '0;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (MAXL + 3) begin settle(); advance(); end
  endtask

  task automatic test_reset();
    clear_inputs();
    now = 0;
    reset = 1; pair_valid = 1; valid_even = 1; valid_odd = 1;
    #3;
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b000) begin
      bad++; $display("FAIL reset_outputs: got %b required 000", {issue_even, issue_odd, pair_accept});
    end
    total++;
    if (busy !== '0 || stall_cycles !== '0) begin
      bad++; $display("FAIL reset_state: busy=%h stall=%0d required 0/0", busy, stall_cycles);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
    clear_inputs();
    @(posedge clk); now++; #1;
  endtask

  task automatic test_independent();
    drain();
    pair_valid = 1; valid_even = 1; valid_odd = 1;
    ra_even = 1; rb_even = 2; use_even = 3'b011; rt_addr_even = 3; reg_write_even = 1; lat_even = 2;
    ra_odd = 5; rb_odd = 6; use_odd = 3'b011; rt_addr_odd = 4; reg_write_odd = 1; lat_odd = 6;
    settle();
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b111 || {exp_ie, exp_io, exp_acc} !== 3'b111) begin
      bad++; $display("FAIL indep_issue: got %b required 111", {issue_even, issue_odd, pair_accept});
    end
    advance();
    clear_inputs();
    total++;
    if (int'(dut.u_bank.cnt[3]) !== 2 || int'(dut.u_bank.cnt[4]) !== 6) begin
      bad++; $display("FAIL indep_counters: cnt3=%0d cnt4=%0d required 2/6",
                      dut.u_bank.cnt[3], dut.u_bank.cnt[4]);
    end
  endtask

  task automatic test_intra_raw();
    int stall0, n_issue;
    drain();
    stall0 = int'(stall_cycles);
    pair_valid = 1; valid_even = 1; valid_odd = 1;
    rt_addr_even = 3; reg_write_even = 1; lat_even = 2;
    ra_odd = 3; use_odd = 3'b001;
    settle();
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b100) begin
      bad++; $display("FAIL raw_split: got %b required 100", {issue_even, issue_odd, pair_accept});
    end
    advance();
    n_issue = -1;
    for (int n = 1; n < 20 && n_issue < 0; n++) begin
      settle();
      total++;
      if (issue_even !== 1'b0 || issue_odd !== exp_io || pair_accept !== exp_acc) begin
        bad++; $display("FAIL raw_wait: cycle %0d got %b required 0%b%b", n,
                        {issue_even, issue_odd, pair_accept}, exp_io, exp_acc);
      end
      if (issue_odd === 1'b1) n_issue = n;
      advance();
    end
    clear_inputs();
    total++;
    if (n_issue !== 3 - THR) begin
      bad++; $display("FAIL raw_issue_cycle: got %0d required %0d", n_issue, 3 - THR);
    end
    total++;
    if (int'(stall_cycles) !== stall0 + 3 - THR) begin
      bad++; $display("FAIL raw_stall_count: got %0d required %0d", stall_cycles, stall0 + 3 - THR);
    end
  endtask

  task automatic test_waw();
    int n_issue;
    drain();
    pair_valid = 1; valid_even = 1; rt_addr_even = 7; reg_write_even = 1; lat_even = 5;
    settle(); advance();
    lat_even = 2;
    n_issue = -1;
    for (int n = 0; n < 20 && n_issue < 0; n++) begin
      settle();
      total++;
      if (issue_even !== exp_ie || pair_accept !== exp_acc || issue_odd !== 1'b0) begin
        bad++; $display("FAIL waw_cycle: cycle %0d got %b required %b%b", n,
                        {issue_even, pair_accept}, exp_ie, exp_acc);
      end
      if (issue_even === 1'b1) n_issue = n;
      advance();
    end
    clear_inputs();
    total++;
    if (n_issue !== 4) begin
      bad++; $display("FAIL waw_issue_cycle: got %0d required 4", n_issue);
    end
    total++;
    if (int'(dut.u_bank.cnt[7]) !== 2) begin
      bad++; $display("FAIL waw_reload: got %0d required 2", dut.u_bank.cnt[7]);
    end
  endtask

  task automatic test_flush();
    drain();
    pair_valid = 1; valid_even = 1; valid_odd = 1;
    rt_addr_even = 3; reg_write_even = 1; lat_even = 4;
    ra_odd = 3; use_odd = 3'b001;
    settle(); advance();
    settle();
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b000) begin
      bad++; $display("FAIL flush_wait: got %b required 000", {issue_even, issue_odd, pair_accept});
    end
    advance();
    flush = 1;
    settle();
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b001 || exp_acc !== 1'b1) begin
      bad++; $display("FAIL flush_discard: got %b required 001", {issue_even, issue_odd, pair_accept});
    end
    advance();
    clear_inputs();
    total++;
    if (int'(dut.u_bank.cnt[3]) !== 2 || busy[3] !== 1'b1) begin
      bad++; $display("FAIL flush_counter: got %0d required 2", dut.u_bank.cnt[3]);
    end
    pair_valid = 1; valid_even = 1; rt_addr_even = 20; reg_write_even = 1; lat_even = 1;
    settle();
    total++;
    if ({issue_even, pair_accept} !== 2'b11) begin
      bad++; $display("FAIL flush_state_pair: got %b required 11", {issue_even, pair_accept});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_lat_clamp();
    drain();
    pair_valid = 1; valid_even = 1; valid_odd = 1;
    rt_addr_even = 9;  reg_write_even = 1; lat_even = 0;
    rt_addr_odd  = 10; reg_write_odd  = 1; lat_odd  = 15;
    settle();
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b111) begin
      bad++; $display("FAIL clamp_issue: got %b required 111", {issue_even, issue_odd, pair_accept});
    end
    advance();
    clear_inputs();
    total++;
    if (int'(dut.u_bank.cnt[9]) !== 1 || int'(dut.u_bank.cnt[10]) !== 7) begin
      bad++; $display("FAIL clamp_counters: cnt9=%0d cnt10=%0d required 1/7",
                      dut.u_bank.cnt[9], dut.u_bank.cnt[10]);
    end
  endtask

  task automatic test_random();
    bit pending;
    logic [NR-1:0] eb;
    pending = 0;
    clear_inputs();
    for (int c = 0; c < 800; c++) begin
      if (!pending) begin
        pair_valid = ($urandom_range(0, 3) != 0);
        valid_even = $urandom_range(0, 1); valid_odd = $urandom_range(0, 1);
        ra_even = AW'($urandom_range(0, 7)); rb_even = AW'($urandom_range(0, 7));
        rc_even = AW'($urandom_range(0, 7)); ra_odd = AW'($urandom_range(0, 7));
        rb_odd = AW'($urandom_range(0, 7)); rt_st_odd = AW'($urandom_range(0, 7));
        use_even = 3'($urandom_range(0, 7)); use_odd = 3'($urandom_range(0, 7));
        rt_addr_even = AW'($urandom_range(0, 7)); rt_addr_odd = AW'($urandom_range(0, 7));
        reg_write_even = $urandom_range(0, 1); reg_write_odd = $urandom_range(0, 1);
        lat_even = CW'($urandom_range(0, 15)); lat_odd = CW'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 15) == 0);
      settle();
      for (int r = 0; r < NR; r++) eb[r] = (cnt_of(r) != 0);
      total++;
      if (issue_even !== exp_ie || issue_odd !== exp_io || pair_accept !== exp_acc) begin
        bad++; $display("FAIL rand_issue: cycle %0d got %b required %b%b%b", c,
                        {issue_even, issue_odd, pair_accept}, exp_ie, exp_io, exp_acc);
      end
      total++;
      if (busy !== eb) begin
        bad++; $display("FAIL rand_busy: cycle %0d got %h required %h", c, busy, eb);
      end
      total++;
      if (int'(stall_cycles) !== stall_m) begin
        bad++; $display("FAIL rand_stall: cycle %0d got %0d required %0d", c, stall_cycles, stall_m);
      end
      pending = pair_valid && !exp_acc;
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    reset = 1; #2; model_reset();
    @(negedge clk); reset = 0;
    drain();
    pair_valid = 1; valid_even = 1; valid_odd = 1;
    rt_addr_even = 3; reg_write_even = 1; lat_even = 5;
    ra_odd = 3; use_odd = 3'b001;
    settle(); advance();
    settle(); advance();
    total++;
    if (int'(dut.u_bank.cnt[3]) !== 4 || split !== 1'b1) begin
      bad++; $display("FAIL areset_setup: cnt3=%0d required 4", dut.u_bank.cnt[3]);
    end
    #2;
    reset = 1;
    #1;
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b000) begin
      bad++; $display("FAIL areset_outputs: got %b required 000", {issue_even, issue_odd, pair_accept});
    end
    total++;
    if (busy !== '0 || stall_cycles !== '0) begin
      bad++; $display("FAIL areset_clear: busy=%h stall=%0d required 0/0", busy, stall_cycles);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
    #1;
    predict();
    total++;
    if ({issue_even, issue_odd, pair_accept} !== 3'b100 || exp_ie !== 1'b1) begin
      bad++; $display("FAIL areset_state_pair: got %b required 100", {issue_even, issue_odd, pair_accept});
    end
    advance();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_independent();
    test_intra_raw();
    test_waw();
    test_flush();
    test_lat_clamp();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
